// File: rtl/ddr3_arb_pkg.sv
// Shared types for the two-port DDR3 request arbiter and its refresh scheduler.
package ddr3_arb_pkg;

  localparam int AW_DEF = 26;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    G_P0  = 2'd0,
    G_P1  = 2'd1,
    G_REF = 2'd2
  } grant_t;

endpackage

// File: rtl/ddr3_refresh_sched.sv
// Refresh interval timer and saturating refresh-debt counter.
// A tick that coincides with a completed refresh leaves the debt unchanged.
module ddr3_refresh_sched #(
  parameter int REFRESH_CYCLES = 779,
  parameter int POSTPONE_MAX   = 8,
  parameter int URGENT_LEVEL   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_refresh_done,
  output logic [3:0] o_debt,
  output logic       o_err_overrun,
  output logic       o_urgent,
  output logic       o_pending
);

  localparam int TW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(REFRESH_CYCLES - 1);
  localparam logic [3:0] DEBT_MAX = 4'(POSTPONE_MAX);
  localparam logic [3:0] DEBT_URG = 4'(URGENT_LEVEL);

  logic [TW-1:0] r_timer;
  logic [3:0]    r_debt;
  logic          r_err_overrun;
  logic          w_tick;

  assign w_tick = (r_timer == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer       <= '0;
      r_debt        <= 4'd0;
      r_err_overrun <= 1'b0;
    end else begin
      r_timer <= w_tick ? '0 : r_timer + 1'b1;
      if (w_tick && !i_refresh_done) begin
        // At the postponement limit a tick is lost and flagged instead of counted.
        if (r_debt == DEBT_MAX) begin
          r_err_overrun <= 1'b1;
        end else begin
          r_debt <= r_debt + 4'd1;
        end
      end else if (!w_tick && i_refresh_done && (r_debt != 4'd0)) begin
        r_debt <= r_debt - 4'd1;
      end
    end
  end

  assign o_debt        = r_debt;
  assign o_err_overrun = r_err_overrun;
  assign o_urgent      = (r_debt >= DEBT_URG);
  assign o_pending     = (r_debt != 4'd0);

endmodule

// File: rtl/ddr3_arbiter.sv
// Round-robin arbiter for two requester ports plus refresh, sharing the single
// rd/wr/refresh command interface of ddr3_controller; all outputs registered.
module ddr3_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int REFRESH_CYCLES = 779,
  parameter int POSTPONE_MAX   = 8,
  parameter int URGENT_LEVEL   = 4,
  parameter int TIMEOUT        = 255,
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_din,
  output logic          p0_ack,
  output logic [DW-1:0] p0_dout,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_din,
  output logic          p1_ack,
  output logic [DW-1:0] p1_dout,
  output logic          ddr_rd,
  output logic          ddr_wr,
  output logic          ddr_refresh,
  output logic [AW-1:0] ddr_addr,
  output logic [DW-1:0] ddr_din,
  input  logic [DW-1:0] ddr_dout,
  input  logic          ddr_data_ready,
  input  logic          ddr_busy,
  output logic [3:0]    refresh_debt,
  output logic          err_overrun,
  output logic          err_timeout
);

  localparam int TMW = $clog2(TIMEOUT + 1);
  localparam logic [TMW-1:0] TMO_LIMIT = TMW'(TIMEOUT);

  state_t        r_state, w_state_nxt;
  grant_t        r_grant, w_grant_nxt;
  logic          r_rr;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic [TMW-1:0] r_tmo;
  logic          r_got;
  logic          r_ddr_rd, r_ddr_wr, r_ddr_refresh;
  logic          r_p0_ack, r_p1_ack;
  logic [DW-1:0] r_p0_dout, r_p1_dout;
  logic          r_err_timeout;

  logic          w_decide, w_complete, w_timeout, w_enter_done;
  logic          w_urgent, w_pending, w_refresh_done, w_is_read;
  logic          w_sel_p1, w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_din;

  ddr3_refresh_sched #(
    .REFRESH_CYCLES(REFRESH_CYCLES),
    .POSTPONE_MAX  (POSTPONE_MAX),
    .URGENT_LEVEL  (URGENT_LEVEL)
  ) u_sched (
    .clk           (clk),
    .reset         (reset),
    .i_refresh_done(w_refresh_done),
    .o_debt        (refresh_debt),
    .o_err_overrun (err_overrun),
    .o_urgent      (w_urgent),
    .o_pending     (w_pending)
  );

  assign w_refresh_done = (r_state == DONE) && (r_grant == G_REF);
  assign w_is_read      = (r_grant != G_REF) && !r_we;
  assign w_enter_done   = (r_state == WAIT) && (w_complete || w_timeout);

  assign w_sel_p1   = (w_grant_nxt == G_P1);
  assign w_sel_we   = w_sel_p1 ? p1_we   : p0_we;
  assign w_sel_addr = w_sel_p1 ? p1_addr : p0_addr;
  assign w_sel_din  = w_sel_p1 ? p1_din  : p0_din;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_decide    = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!ddr_busy) begin
          if (w_urgent) begin
            w_decide    = 1'b1;
            w_grant_nxt = G_REF;
          end else if (p0_req && p1_req) begin
            // r_rr remembers the last served port; the other one goes next.
            w_decide    = 1'b1;
            w_grant_nxt = r_rr ? G_P0 : G_P1;
          end else if (p0_req) begin
            w_decide    = 1'b1;
            w_grant_nxt = G_P0;
          end else if (p1_req) begin
            w_decide    = 1'b1;
            w_grant_nxt = G_P1;
          end else if (w_pending) begin
            w_decide    = 1'b1;
            w_grant_nxt = G_REF;
          end
          if (w_decide) begin
            w_state_nxt = ISSUE;
          end
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (!ddr_busy && (!w_is_read || r_got)) begin
          w_complete  = 1'b1;
          w_state_nxt = DONE;
        end else if (r_tmo == TMO_LIMIT) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= G_P0;
      r_rr          <= 1'b0;
      r_ddr_rd      <= 1'b0;
      r_ddr_wr      <= 1'b0;
      r_ddr_refresh <= 1'b0;
      r_p0_ack      <= 1'b0;
      r_p1_ack      <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ddr_rd      <= w_decide && (w_grant_nxt != G_REF) && !w_sel_we;
      r_ddr_wr      <= w_decide && (w_grant_nxt != G_REF) && w_sel_we;
      r_ddr_refresh <= w_decide && (w_grant_nxt == G_REF);
      r_p0_ack      <= w_enter_done && (r_grant == G_P0);
      r_p1_ack      <= w_enter_done && (r_grant == G_P1);
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
      if (w_decide) begin
        r_grant <= w_grant_nxt;
        if (w_grant_nxt != G_REF) begin
          r_rr <= w_sel_p1;
        end
      end
    end
  end

  // Command fields are latched at decision time so requesters may change them after ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_decide && (w_grant_nxt != G_REF)) begin
      r_we   <= w_sel_we;
      r_addr <= w_sel_addr;
      r_din  <= w_sel_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo     <= '0;
      r_got     <= 1'b0;
      r_p0_dout <= '0;
      r_p1_dout <= '0;
    end else if (w_decide) begin
      r_tmo <= '0;
      r_got <= 1'b0;
    end else if (r_state == WAIT) begin
      if (!w_timeout) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_is_read && ddr_data_ready && !r_got) begin
        r_got <= 1'b1;
        if (r_grant == G_P1) begin
          r_p1_dout <= ddr_dout;
        end else begin
          r_p0_dout <= ddr_dout;
        end
      end
    end
  end

  assign ddr_rd      = r_ddr_rd;
  assign ddr_wr      = r_ddr_wr;
  assign ddr_refresh = r_ddr_refresh;
  assign ddr_addr    = r_addr;
  assign ddr_din     = r_din;
  assign p0_ack      = r_p0_ack;
  assign p1_ack      = r_p1_ack;
  assign p0_dout     = r_p0_dout;
  assign p1_dout     = r_p1_dout;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_ddr3_arbiter.sv
// Directed bench for ddr3_arbiter with a small behavioural controller model.
module tb_ddr3_arbiter;

  localparam int AW = 26;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_din = '0, p1_din = '0;
  logic          p0_ack, p1_ack;
  logic [DW-1:0] p0_dout, p1_dout;
  logic          ddr_rd, ddr_wr, ddr_refresh;
  logic [AW-1:0] ddr_addr;
  logic [DW-1:0] ddr_din;
  logic [DW-1:0] ddr_dout = '0;
  logic          ddr_data_ready = 1'b0;
  logic          ddr_busy = 1'b0;
  logic [3:0]    refresh_debt;
  logic          err_overrun, err_timeout;

  always #5 clk = ~clk;

  ddr3_arbiter #(
    .REFRESH_CYCLES(20), .POSTPONE_MAX(8), .URGENT_LEVEL(4), .TIMEOUT(16), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din),
    .p0_ack(p0_ack), .p0_dout(p0_dout),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
    .p1_ack(p1_ack), .p1_dout(p1_dout),
    .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_refresh(ddr_refresh),
    .ddr_addr(ddr_addr), .ddr_din(ddr_din), .ddr_dout(ddr_dout),
    .ddr_data_ready(ddr_data_ready), .ddr_busy(ddr_busy),
    .refresh_debt(refresh_debt), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: busy for busy_len cycles per command, read data 10 cycles after ddr_rd.
  int         busy_len = 6;
  bit         hold_busy = 1'b0;
  bit         drop_ready = 1'b0;
  int         busy_cnt = 0;
  int         rd_cnt = 0;
  logic [7:0] rd_addr = '0;
  logic [DW-1:0] mem [256];

  always @(negedge clk) begin
    if (reset) begin
      busy_cnt       <= 0;
      rd_cnt         <= 0;
      ddr_data_ready <= 1'b0;
      ddr_busy       <= hold_busy;
    end else begin
      ddr_data_ready <= 1'b0;
      if (rd_cnt == 1) begin
        if (drop_ready) ddr_dout <= 16'hDEAD;
        else begin
          ddr_data_ready <= 1'b1;
          ddr_dout       <= mem[rd_addr];
        end
      end
      if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
      if (ddr_wr) mem[ddr_addr[7:0]] <= ddr_din;
      if (ddr_rd) begin
        rd_addr <= ddr_addr[7:0];
        rd_cnt  <= 10;
      end
      if (ddr_wr || ddr_rd || ddr_refresh) begin
        busy_cnt <= busy_len;
        ddr_busy <= hold_busy || (busy_len != 0);
      end else begin
        busy_cnt <= (busy_cnt > 0) ? busy_cnt - 1 : 0;
        ddr_busy <= hold_busy || (busy_cnt > 1);
      end
    end
  end

  // Monotonic event counters and last-command capture.
  int n_wr = 0, n_rd = 0, n_ref = 0, n_ack0 = 0, n_ack1 = 0;
  int rd_cyc = 0, ack0_cyc = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_din = '0;
  always @(negedge clk) begin
    if (ddr_wr) begin
      n_wr     <= n_wr + 1;
      cmd_addr <= ddr_addr;
      cmd_din  <= ddr_din;
    end
    if (ddr_rd) begin
      n_rd     <= n_rd + 1;
      rd_cyc   <= cyc;
      cmd_addr <= ddr_addr;
    end
    if (ddr_refresh) n_ref <= n_ref + 1;
    if (p0_ack) begin
      n_ack0   <= n_ack0 + 1;
      ack0_cyc <= cyc;
    end
    if (p1_ack) n_ack1 <= n_ack1 + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset  = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_txn(input int port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] din, output bit ok, output logic [DW-1:0] dout);
    ok   = 1'b0;
    dout = '0;
    if (port == 0) begin
      p0_we = we; p0_addr = addr; p0_din = din; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_din = din; p1_req = 1'b1;
    end
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (port == 0 && p0_ack) begin ok = 1'b1; dout = p0_dout; end
      if (port == 1 && p1_ack) begin ok = 1'b1; dout = p1_dout; end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  typedef struct {
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
  } vec_t;

  vec_t vt[8];

  initial begin : main
    bit            ok;
    logic [DW-1:0] dout;
    int            t0, w1, w2, a1, first_cmd, maxd, minref, nref;
    int            b_wr, b_rd, b_ref, b_ack0, b_oth;
    int            seq[$];
    bit            fin;

    vt[0] = '{0, 1'b1, 26'h0000001, 16'h5678, 16'h0000};
    vt[1] = '{1, 1'b1, 26'h0000002, 16'hABCD, 16'h0000};
    vt[2] = '{1, 1'b0, 26'h0000002, 16'h0000, 16'hABCD};
    vt[3] = '{0, 1'b0, 26'h0000001, 16'h0000, 16'h5678};
    vt[4] = '{0, 1'b1, 26'h3FFFFFF, 16'hFFFF, 16'h0000};
    vt[5] = '{1, 1'b0, 26'h3FFFFFF, 16'h0000, 16'hFFFF};
    vt[6] = '{1, 1'b1, 26'h2AAAA55, 16'h0000, 16'h0000};
    vt[7] = '{0, 1'b0, 26'h2AAAA55, 16'h1111, 16'h0000};

    // Reset state
    tick(); tick(); tick();
    chk("rst_pulses", {25'd0, ddr_rd, ddr_wr, ddr_refresh, p0_ack, p1_ack, err_overrun, err_timeout}, 32'd0);
    chk("rst_addr", 32'(ddr_addr), 32'd0);
    chk("rst_din", 32'(ddr_din), 32'd0);
    chk("rst_dout", {p0_dout, p1_dout}, 32'd0);
    chk("rst_debt", 32'(refresh_debt), 32'd0);
    reset = 1'b0;

    // Minimum latency and back-to-back spacing with an always-ready controller
    busy_len = 0;
    do_reset();
    p0_we = 1'b1; p0_addr = 26'h10; p0_din = 16'h1111; p0_req = 1'b1;
    t0 = cyc; w1 = -100; w2 = -100; a1 = -100; fin = 1'b0;
    for (int i = 0; i < 50 && !fin; i++) begin
      tick();
      if (ddr_wr) begin
        if (w1 < 0) w1 = cyc; else w2 = cyc;
      end
      if (p0_ack) begin
        if (a1 < 0) a1 = cyc;
        else begin p0_req = 1'b0; fin = 1'b1; end
      end
    end
    p0_req = 1'b0;
    chk("lat_wr", 32'(w1 - t0), 32'd1);
    chk("lat_ack", 32'(a1 - t0), 32'd3);
    chk("b2b_gap", 32'(w2 - w1), 32'd4);

    // Round-robin contention
    busy_len = 6;
    do_reset();
    p0_we = 1'b1; p0_addr = 26'h20; p0_din = 16'hAAAA;
    p1_we = 1'b1; p1_addr = 26'h21; p1_din = 16'hBBBB;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 300 && seq.size() < 6; i++) begin
      tick();
      if (p0_ack) seq.push_back(0);
      if (p1_ack) seq.push_back(1);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("rr_count", 32'(seq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), (i < seq.size()) ? 32'(seq[i]) : 32'd9, (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Table of single transactions
    do_reset();
    for (int v = 0; v < 8; v++) begin
      b_wr = n_wr; b_rd = n_rd;
      b_oth = (vt[v].port == 0) ? n_ack1 : n_ack0;
      do_txn(vt[v].port, vt[v].we, vt[v].addr, vt[v].din, ok, dout);
      chk($sformatf("v%0d_ack", v), 32'(ok), 32'd1);
      chk($sformatf("v%0d_nwr", v), 32'(n_wr - b_wr), vt[v].we ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_nrd", v), 32'(n_rd - b_rd), vt[v].we ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_addr", v), 32'(cmd_addr), 32'(vt[v].addr));
      if (vt[v].we) chk($sformatf("v%0d_din", v), 32'(cmd_din), 32'(vt[v].din));
      else          chk($sformatf("v%0d_dout", v), 32'(dout), 32'(vt[v].exp_dout));
      chk($sformatf("v%0d_other_ack", v), 32'((vt[v].port == 0 ? n_ack1 : n_ack0) - b_oth), 32'd0);
    end
    chk("tbl_errs", {30'd0, err_overrun, err_timeout}, 32'd0);

    // Idle refresh: one refresh per tick, debt drains each time
    do_reset();
    b_ref = n_ref; maxd = 0;
    for (int i = 0; i < 95; i++) begin
      tick();
      if (int'(refresh_debt) > maxd) maxd = int'(refresh_debt);
    end
    chk("idle_nref", 32'(n_ref - b_ref), 32'd4);
    chk("idle_debt", 32'(refresh_debt), 32'd0);
    chk("idle_maxdebt", 32'(maxd), 32'd1);

    // Saturated ports: refresh deferred until debt reaches the urgent level
    do_reset();
    p0_we = 1'b1; p0_addr = 26'h30; p0_din = 16'h3030;
    p1_we = 1'b1; p1_addr = 26'h31; p1_din = 16'h3131;
    p0_req = 1'b1; p1_req = 1'b1;
    maxd = 0; minref = 15; nref = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (int'(refresh_debt) > maxd) maxd = int'(refresh_debt);
      if (ddr_refresh) begin
        nref++;
        if (int'(refresh_debt) < minref) minref = int'(refresh_debt);
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("post_maxdebt", 32'(maxd), 32'd4);
    chk("post_refdebt", 32'(minref), 32'd4);
    chk("post_refs", 32'(nref > 0), 32'd1);
    chk("post_overrun", 32'(err_overrun), 32'd0);

    // Controller busy during init: debt saturates, then overrun
    hold_busy = 1'b1;
    do_reset();
    b_ref = n_ref;
    for (int i = 0; i < 170; i++) tick();
    chk("busy_debt8", 32'(refresh_debt), 32'd8);
    chk("busy_no_ovr", 32'(err_overrun), 32'd0);
    for (int i = 0; i < 35; i++) tick();
    chk("busy_sat", 32'(refresh_debt), 32'd8);
    chk("busy_ovr", 32'(err_overrun), 32'd1);
    chk("busy_noref", 32'(n_ref - b_ref), 32'd0);
    p0_we = 1'b1; p0_addr = 26'h40; p0_din = 16'h4040; p0_req = 1'b1;
    hold_busy = 1'b0;
    first_cmd = 0;
    for (int i = 0; i < 40 && first_cmd == 0; i++) begin
      tick();
      if (ddr_refresh) first_cmd = 3;
      else if (ddr_wr) first_cmd = 2;
      else if (ddr_rd) first_cmd = 1;
    end
    p0_req = 1'b0;
    chk("busy_first_ref", 32'(first_cmd), 32'd3);

    // Read timeout: ack still pulses, dout keeps its previous value
    do_reset();
    do_txn(0, 1'b1, 26'h5, 16'h1234, ok, dout);
    do_txn(0, 1'b1, 26'h6, 16'h9999, ok, dout);
    do_txn(0, 1'b0, 26'h5, 16'h0, ok, dout);
    chk("tmo_pre_dout", 32'(dout), 32'h1234);
    chk("tmo_pre_err", 32'(err_timeout), 32'd0);
    drop_ready = 1'b1;
    b_ack0 = n_ack0;
    do_txn(0, 1'b0, 26'h6, 16'h0, ok, dout);
    chk("tmo_ack", 32'(ok), 32'd1);
    chk("tmo_nack", 32'(n_ack0 - b_ack0), 32'd1);
    chk("tmo_err", 32'(err_timeout), 32'd1);
    chk("tmo_dout_held", 32'(dout), 32'h1234);
    chk("tmo_ack_delay", 32'(ack0_cyc - rd_cyc), 32'd18);
    drop_ready = 1'b0;
    do_txn(0, 1'b1, 26'h7, 16'h7777, ok, dout);
    chk("tmo_recover", 32'(ok), 32'd1);

    // Reset asserted while a read sits in WAIT
    drop_ready = 1'b1;
    b_rd = n_rd;
    p0_we = 1'b0; p0_addr = 26'h6; p0_req = 1'b1;
    for (int i = 0; i < 60 && n_rd == b_rd; i++) tick();
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_pulses", {21'd0, ddr_rd, ddr_wr, ddr_refresh, p0_ack, p1_ack, err_overrun, err_timeout, refresh_debt}, 32'd0);
    chk("mid_rst_dout", 32'(p0_dout), 32'd0);
    chk("mid_rst_addr", 32'(ddr_addr), 32'd0);
    p0_req = 1'b0;
    drop_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    b_wr = n_wr; b_rd = n_rd; b_ack0 = n_ack0;
    for (int i = 0; i < 15; i++) tick();
    chk("mid_rst_quiet", 32'((n_wr - b_wr) + (n_rd - b_rd) + (n_ack0 - b_ack0)), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
